// File: rtl/lt1_cmp.sv
// lt1_cmp: registered WIDTH-bit comparator (lt/eq/gt) with a saturating count of lt results.
// Define LT1_CMP_SIGNED_EN to compare i0/i1 as two's-complement instead of unsigned.
module lt1_cmp #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             in_valid,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             out_valid,
    output logic [CNT_W-1:0] lt_count
);
    logic less, greater;
`ifdef LT1_CMP_SIGNED_EN
    assign less    = $signed(i0) < $signed(i1);
    assign greater = $signed(i0) > $signed(i1);
`else
    assign less    = i0 < i1;
    assign greater = i0 > i1;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            out_valid <= 1'b0;
            lt_count  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                lt <= less;
                eq <= i0 == i1;
                gt <= greater;
                if (less && lt_count != '1) lt_count <= lt_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lt1_cmp.sv
// tb_lt1_cmp: randomized and directed checks of lt1_cmp against an integer-ordering model.
module tb_lt1_cmp;
    localparam int WIDTH = 2;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic [WIDTH-1:0] i0 = '0, i1 = '0;
    logic lt, eq, gt, out_valid;
    logic [CNT_W-1:0] lt_count;

    int errors = 0;
    int checks = 0;
    int m_lt = 0, m_eq = 0, m_gt = 0, m_ov = 0, m_cnt = 0;

    lt1_cmp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .in_valid(in_valid),
        .lt(lt), .eq(eq), .gt(gt), .out_valid(out_valid), .lt_count(lt_count)
    );

    always #5 clk = ~clk;

    function automatic int val(input logic [WIDTH-1:0] x);
`ifdef LT1_CMP_SIGNED_EN
        return (int'(x) >= (1 << (WIDTH - 1))) ? int'(x) - (1 << WIDTH) : int'(x);
`else
        return int'(x);
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input int a, input int b);
        int va, vb;
        reset = r;
        in_valid = v;
        i0 = WIDTH'(a);
        i1 = WIDTH'(b);
        @(posedge clk);
        #1;
        va = val(i0);
        vb = val(i1);
        if (r) begin
            m_lt = 0; m_eq = 0; m_gt = 0; m_ov = 0; m_cnt = 0;
        end else begin
            m_ov = int'(v);
            if (v) begin
                m_lt = int'(va < vb);
                m_eq = int'(va == vb);
                m_gt = int'(va > vb);
                if (va < vb && m_cnt < CNT_MAX) m_cnt++;
            end
        end
        chk("lt", int'(lt), m_lt);
        chk("eq", int'(eq), m_eq);
        chk("gt", int'(gt), m_gt);
        chk("out_valid", int'(out_valid), m_ov);
        chk("lt_count", int'(lt_count), m_cnt);
        if (out_valid) chk("one_hot", int'(lt) + int'(eq) + int'(gt), 1);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 3);
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        step(0, 1, 3, 2);
        step(0, 1, 3, 1);
        step(0, 1, 0, 1);
        step(0, 0, 3, 0);
        step(0, 0, 2, 1);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                step(0, 1, a, b);
        step(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
